// File: rtl/gat_pkg.sv
// gat_pkg: shared widths, CSR node_info / H element bundles and the
// read-scheduler state encoding.
package gat_pkg;
  localparam int DATA_WIDTH      = 8;
  localparam int H_NUM_OF_ROWS   = 5;
  localparam int H_NUM_OF_COLS   = 5;
  localparam int NUM_OF_NODES    = 5;
  localparam int BRAM_ADDR_WIDTH = 32;

  localparam int COL_IDX_WIDTH   = $clog2(H_NUM_OF_COLS);
  localparam int ROW_LEN_WIDTH   = $clog2(H_NUM_OF_COLS);
  localparam int NUM_NODE_WIDTH  = $clog2(NUM_OF_NODES);
  localparam int NODE_INFO_WIDTH = ROW_LEN_WIDTH + NUM_NODE_WIDTH + 1;
  localparam int H_INDEX_WIDTH   = $clog2(H_NUM_OF_ROWS);
  // row counter must also hold the terminal value H_NUM_OF_ROWS
  localparam int ROW_CNT_WIDTH   = $clog2(H_NUM_OF_ROWS + 1);

  typedef struct packed {
    logic [ROW_LEN_WIDTH-1:0]  row_len;
    logic [NUM_NODE_WIDTH-1:0] num_node;
    logic                      flag;
  } node_info_t;

  typedef struct packed {
    logic [COL_IDX_WIDTH-1:0]  col_idx;
    logic [DATA_WIDTH-1:0]     value;
    logic [H_INDEX_WIDTH-1:0]  row_idx;
    logic [NUM_NODE_WIDTH-1:0] num_node;
    logic                      flag;
    logic                      last;
  } h_elem_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INFO_REQ,
    S_INFO_CAP,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;
endpackage

// File: rtl/h_csr_read_sched_if.sv
// h_csr_read_sched_if: H BRAM port B bundle plus the tagged element
// stream and run control of the CSR read scheduler.
interface h_csr_read_sched_if;
  import gat_pkg::*;

  logic start;
  logic H_col_idx_BRAM_load_done;
  logic H_value_BRAM_load_done;
  logic H_node_info_BRAM_load_done;

  logic                       H_node_info_BRAM_enb;
  logic [BRAM_ADDR_WIDTH-1:0] H_node_info_BRAM_addrb;
  logic [NODE_INFO_WIDTH-1:0] H_node_info_BRAM_dout;
  logic                       H_col_idx_BRAM_enb;
  logic [BRAM_ADDR_WIDTH-1:0] H_col_idx_BRAM_addrb;
  logic [COL_IDX_WIDTH-1:0]   H_col_idx_BRAM_dout;
  logic                       H_value_BRAM_enb;
  logic [BRAM_ADDR_WIDTH-1:0] H_value_BRAM_addrb;
  logic [DATA_WIDTH-1:0]      H_value_BRAM_dout;

  logic                      out_valid;
  logic                      out_ready;
  logic [COL_IDX_WIDTH-1:0]  out_col_idx;
  logic [DATA_WIDTH-1:0]     out_value;
  logic [H_INDEX_WIDTH-1:0]  out_row_idx;
  logic [NUM_NODE_WIDTH-1:0] out_num_node;
  logic                      out_flag;
  logic                      out_row_last;
  logic                      busy;
  logic                      done;

  modport master (
    input  start, H_col_idx_BRAM_load_done, H_value_BRAM_load_done,
    input  H_node_info_BRAM_load_done,
    input  H_node_info_BRAM_dout, H_col_idx_BRAM_dout, H_value_BRAM_dout,
    input  out_ready,
    output H_node_info_BRAM_enb, H_node_info_BRAM_addrb,
    output H_col_idx_BRAM_enb, H_col_idx_BRAM_addrb,
    output H_value_BRAM_enb, H_value_BRAM_addrb,
    output out_valid, out_col_idx, out_value, out_row_idx,
    output out_num_node, out_flag, out_row_last, busy, done
  );

  modport slave (
    output start, H_col_idx_BRAM_load_done, H_value_BRAM_load_done,
    output H_node_info_BRAM_load_done,
    output H_node_info_BRAM_dout, H_col_idx_BRAM_dout, H_value_BRAM_dout,
    output out_ready,
    input  H_node_info_BRAM_enb, H_node_info_BRAM_addrb,
    input  H_col_idx_BRAM_enb, H_col_idx_BRAM_addrb,
    input  H_value_BRAM_enb, H_value_BRAM_addrb,
    input  out_valid, out_col_idx, out_value, out_row_idx,
    input  out_num_node, out_flag, out_row_last, busy, done
  );
endinterface

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: 2-entry synchronous FIFO of H elements; the
// caller guarantees no push when full and no pop when empty.
module stream_skid_fifo
  import gat_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  h_elem_t    din,
  output h_elem_t    dout,
  output logic [1:0] count
);
  h_elem_t    mem_q [2];
  h_elem_t    mem_d [2];
  logic       wr_q, wr_d;
  logic       rd_q, rd_d;
  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = din;
      wr_d        = ~wr_q;
    end
    if (pop) rd_d = ~rd_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/h_csr_read_sched.sv
// h_csr_read_sched: walks CSR node_info row by row and streams tagged
// (col_idx, value) elements of H to the SpMM stage over valid/ready.
module h_csr_read_sched
  import gat_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  h_csr_read_sched_if.master bus
);
  localparam int RCW = ROW_CNT_WIDTH;

  state_t                     state_q, state_d;
  logic [RCW-1:0]             row_cnt_q, row_cnt_d;
  logic [BRAM_ADDR_WIDTH-1:0] nnz_ptr_q, nnz_ptr_d;
  logic [ROW_LEN_WIDTH-1:0]   rem_q, rem_d;
  logic [NUM_NODE_WIDTH-1:0]  num_node_q, num_node_d;
  logic                       flag_q, flag_d;
  logic                       infl_q, infl_d;
  h_elem_t                    tag_q, tag_d;

  node_info_t ni;
  h_elem_t    push_elem, head;
  logic [1:0] count;
  logic [2:0] occ;
  logic       push, pop, head_vld, all_loaded;
  logic       last_row, room, issue, ni_enb;

  assign ni         = node_info_t'(bus.H_node_info_BRAM_dout);
  assign all_loaded = bus.H_col_idx_BRAM_load_done
                    & bus.H_value_BRAM_load_done
                    & bus.H_node_info_BRAM_load_done;
  assign last_row   = (row_cnt_q == RCW'(H_NUM_OF_ROWS - 1));
  assign head_vld   = (count != 2'd0);
  assign pop        = head_vld & bus.out_ready;
  assign push       = infl_q;
  // occupancy the FIFO will have once this cycle's pop/push settle
  assign occ        = 3'(count) + 3'(infl_q) - 3'(pop);
  assign room       = (occ < 3'd2);
  assign ni_enb     = (state_q == S_INFO_REQ);

  always_comb begin
    push_elem         = tag_q;
    push_elem.col_idx = bus.H_col_idx_BRAM_dout;
    push_elem.value   = bus.H_value_BRAM_dout;
  end

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    nnz_ptr_d  = nnz_ptr_q;
    rem_d      = rem_q;
    num_node_d = num_node_q;
    flag_d     = flag_q;
    tag_d      = tag_q;
    issue      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start && all_loaded) begin
          row_cnt_d = '0;
          nnz_ptr_d = '0;
          state_d   = S_INFO_REQ;
        end
      end
      S_INFO_REQ: state_d = S_INFO_CAP;
      S_INFO_CAP: begin
        num_node_d = ni.num_node;
        flag_d     = ni.flag;
        if (ni.row_len == '0) begin
          row_cnt_d = row_cnt_q + RCW'(1);
          state_d   = last_row ? S_DRAIN : S_INFO_REQ;
        end else begin
          rem_d   = ni.row_len;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (room) begin
          issue          = 1'b1;
          nnz_ptr_d      = nnz_ptr_q + BRAM_ADDR_WIDTH'(1);
          rem_d          = rem_q - ROW_LEN_WIDTH'(1);
          tag_d          = '0;
          tag_d.row_idx  = H_INDEX_WIDTH'(row_cnt_q);
          tag_d.num_node = num_node_q;
          tag_d.flag     = flag_q;
          tag_d.last     = (rem_q == ROW_LEN_WIDTH'(1));
          if (rem_q == ROW_LEN_WIDTH'(1)) begin
            row_cnt_d = row_cnt_q + RCW'(1);
            state_d   = last_row ? S_DRAIN : S_INFO_REQ;
          end
        end
      end
      S_DRAIN: begin
        if (!head_vld && !infl_q) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    infl_d = issue;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      nnz_ptr_q  <= '0;
      rem_q      <= '0;
      num_node_q <= '0;
      flag_q     <= 1'b0;
      infl_q     <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      nnz_ptr_q  <= nnz_ptr_d;
      rem_q      <= rem_d;
      num_node_q <= num_node_d;
      flag_q     <= flag_d;
      infl_q     <= infl_d;
      tag_q      <= tag_d;
    end
  end

  stream_skid_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (push_elem),
    .dout  (head),
    .count (count)
  );

  assign bus.H_node_info_BRAM_enb   = ni_enb;
  assign bus.H_node_info_BRAM_addrb =
    ni_enb ? BRAM_ADDR_WIDTH'(row_cnt_q) : '0;
  assign bus.H_col_idx_BRAM_enb     = issue;
  assign bus.H_col_idx_BRAM_addrb   = issue ? nnz_ptr_q : '0;
  assign bus.H_value_BRAM_enb       = issue;
  assign bus.H_value_BRAM_addrb     = issue ? nnz_ptr_q : '0;

  assign bus.out_valid    = head_vld;
  assign bus.out_col_idx  = head_vld ? head.col_idx  : '0;
  assign bus.out_value    = head_vld ? head.value    : '0;
  assign bus.out_row_idx  = head_vld ? head.row_idx  : '0;
  assign bus.out_num_node = head_vld ? head.num_node : '0;
  assign bus.out_flag     = head_vld & head.flag;
  assign bus.out_row_last = head_vld & head.last;
  assign bus.busy         = (state_q != S_IDLE);
  assign bus.done         = (state_q == S_DONE);
endmodule

// File: tb/tb_h_csr_read_sched.sv
// tb_h_csr_read_sched: BRAM models, CSR reference model and a
// scoreboard monitor for the H read scheduler.
`timescale 1ns/1ps
module tb_h_csr_read_sched;
  import gat_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  h_csr_read_sched_if bif ();

  h_csr_read_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  logic [ROW_LEN_WIDTH-1:0]  m_len [H_NUM_OF_ROWS];
  logic [NUM_NODE_WIDTH-1:0] m_nn  [H_NUM_OF_ROWS];
  logic                      m_fl  [H_NUM_OF_ROWS];
  logic [COL_IDX_WIDTH-1:0]  m_col [32];
  logic [DATA_WIDTH-1:0]     m_val [32];

  function automatic logic [NODE_INFO_WIDTH-1:0] ni_word(
    input logic [BRAM_ADDR_WIDTH-1:0] a);
    int i;
    i = int'(a);
    if (i >= H_NUM_OF_ROWS) return '0;
    return {m_len[i], m_nn[i], m_fl[i]};
  endfunction

  function automatic int nz_idx(input logic [BRAM_ADDR_WIDTH-1:0] a);
    return (a < 32) ? int'(a) : 0;
  endfunction

  always @(posedge clk) begin
    if (bif.H_node_info_BRAM_enb)
      bif.H_node_info_BRAM_dout <= ni_word(bif.H_node_info_BRAM_addrb);
    if (bif.H_col_idx_BRAM_enb)
      bif.H_col_idx_BRAM_dout <= m_col[nz_idx(bif.H_col_idx_BRAM_addrb)];
    if (bif.H_value_BRAM_enb)
      bif.H_value_BRAM_dout <= m_val[nz_idx(bif.H_value_BRAM_addrb)];
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  h_elem_t exp_q [$];
  int      xfer_cyc [$];
  int      xfer_row [$];
  int      n_xfer = 0;
  int      last_xfer_cyc = 0;
  int      first_valid_cyc = -1;
  int      samp_cyc = 0;
  int      done_cnt = 0;
  logic    hold = 1'b0;
  h_elem_t held, act, expv;

  int rdy_mode = 0;
  int rdy_ph = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: bif.out_ready = 1'b1;
      1: begin
        bif.out_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
        rdy_ph++;
      end
      default: bif.out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      act = {bif.out_col_idx, bif.out_value, bif.out_row_idx,
             bif.out_num_node, bif.out_flag, bif.out_row_last};
      if (hold) begin
        checks++;
        if (!bif.out_valid || act !== held) begin
          errors++;
          $display("FAIL stall_stable act=%0h v=%0b req=%0h", act,
                   bif.out_valid, held);
        end
      end
      if (bif.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bif.out_valid && bif.out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_elem act=%0h req=none", act);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            errors++;
            $display("FAIL elem act=%0h req=%0h", act, expv);
          end
        end
        n_xfer++;
        last_xfer_cyc = cyc;
        xfer_cyc.push_back(cyc);
        xfer_row.push_back(int'(act.row_idx));
      end
      hold = bif.out_valid && !bif.out_ready;
      held = act;
      if (bif.done) begin
        done_cnt++;
        checks++;
        if (exp_q.size() != 0 ||
            (n_xfer > 0 && cyc != last_xfer_cyc + 2)) begin
          errors++;
          $display("FAIL done_timing act=%0d req=%0d left=%0d",
                   cyc, last_xfer_cyc + 2, exp_q.size());
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] r);
    checks++;
    if (a !== r) begin
      errors++;
      $display("FAIL %s act=%0h req=%0h", nm, a, r);
    end
  endtask

  // reference: rows in order, nnz entries consumed contiguously
  task automatic build_expected();
    int p;
    h_elem_t e;
    p = 0;
    for (int r = 0; r < H_NUM_OF_ROWS; r++) begin
      for (int k = 0; k < int'(m_len[r]); k++) begin
        e.col_idx  = m_col[p];
        e.value    = m_val[p];
        e.row_idx  = H_INDEX_WIDTH'(r);
        e.num_node = m_nn[r];
        e.flag     = m_fl[r];
        e.last     = (k == int'(m_len[r]) - 1);
        exp_q.push_back(e);
        p++;
      end
    end
  endtask

  task automatic load_nominal();
    logic [COL_IDX_WIDTH-1:0] c [8];
    logic [DATA_WIDTH-1:0]    v [8];
    c = '{0, 4, 2, 4, 1, 3, 2, 4};
    v = '{2, 9, 7, 8, 6, 5, 3, 1};
    m_len = '{2, 2, 2, 1, 1};
    m_fl  = '{1, 0, 0, 0, 0};
    m_nn  = '{5, 5, 5, 5, 5};
    for (int i = 0; i < 32; i++) begin
      m_col[i] = (i < 8) ? c[i] : '0;
      m_val[i] = (i < 8) ? v[i] : '0;
    end
  endtask

  task automatic prep_run(input int mode);
    rdy_mode = mode;
    rdy_ph = 0;
    n_xfer = 0;
    xfer_cyc.delete();
    xfer_row.delete();
    build_expected();
  endtask

  task automatic pulse_start();
    @(negedge clk);
    bif.start = 1'b1;
    first_valid_cyc = -1;
    @(negedge clk);
    bif.start = 1'b0;
    samp_cyc = cyc;
  endtask

  task automatic wait_done(input string nm, input int base);
    int n;
    n = 0;
    while (done_cnt == base && n < 600) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    chk({nm, "_done_once"}, 64'(done_cnt), 64'(base + 1));
    chk({nm, "_all_seen"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_idle"}, {63'd0, bif.busy}, 64'd0);
  endtask

  task automatic check_idle(input string nm);
    chk({nm, "_enb"}, {61'd0, bif.H_node_info_BRAM_enb,
        bif.H_col_idx_BRAM_enb, bif.H_value_BRAM_enb}, 64'd0);
    chk({nm, "_addr"}, 64'(bif.H_node_info_BRAM_addrb |
        bif.H_col_idx_BRAM_addrb | bif.H_value_BRAM_addrb), 64'd0);
    chk({nm, "_ctl"}, {61'd0, bif.out_valid, bif.busy, bif.done}, 64'd0);
    chk({nm, "_data"}, 64'({bif.out_col_idx, bif.out_value,
        bif.out_row_idx, bif.out_num_node, bif.out_flag,
        bif.out_row_last}), 64'd0);
  endtask

  int base, n, tot, bad, d;

  initial begin
    bif.start = 1'b0;
    bif.H_col_idx_BRAM_load_done = 1'b1;
    bif.H_value_BRAM_load_done = 1'b1;
    bif.H_node_info_BRAM_load_done = 1'b1;
    bif.out_ready = 1'b1;
    load_nominal();
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;

    // start ignored while one BRAM is still loading
    bif.H_value_BRAM_load_done = 1'b0;
    pulse_start();
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (bif.busy || bif.H_node_info_BRAM_enb ||
          bif.H_col_idx_BRAM_enb || bif.H_value_BRAM_enb) bad = 1;
    end
    chk("gate_no_load", 64'(bad), 64'd0);
    bif.H_value_BRAM_load_done = 1'b1;

    // nominal, out_ready=1: latency and row-boundary bubbles
    prep_run(0);
    base = done_cnt;
    pulse_start();
    wait_done("nominal", base);
    chk("nominal_count", 64'(n_xfer), 64'd8);
    chk("first_valid_lat", 64'(first_valid_cyc - samp_cyc), 64'd4);
    for (int i = 1; i < xfer_cyc.size(); i++) begin
      d = (xfer_row[i] == xfer_row[i-1]) ? 1 : 3;
      chk($sformatf("gap_%0d", i), 64'(xfer_cyc[i] - xfer_cyc[i-1]),
          64'(d));
    end

    // backpressure 1-0-0-1 plus a start pulse mid-stream
    prep_run(1);
    base = done_cnt;
    pulse_start();
    n = 0;
    while (n_xfer < 1 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("bp_first_xfer_seen", 64'(n_xfer >= 1), 64'd1);
    pulse_start();
    wait_done("backpressure", base);
    chk("bp_count", 64'(n_xfer), 64'd8);

    // empty row in the middle and at the end
    m_len = '{2, 0, 1, 2, 0};
    m_fl  = '{0, 1, 0, 1, 0};
    m_nn  = '{5, 4, 3, 2, 1};
    for (int i = 0; i < 5; i++) begin
      m_col[i] = COL_IDX_WIDTH'((i * 3 + 1) % 5);
      m_val[i] = DATA_WIDTH'(10 * (i + 1));
    end
    prep_run(0);
    base = done_cnt;
    pulse_start();
    wait_done("empty_row", base);
    chk("empty_count", 64'(n_xfer), 64'd5);

    // reset after three transfers, then replay from the top
    load_nominal();
    prep_run(0);
    base = done_cnt;
    pulse_start();
    n = 0;
    while (n_xfer < 3 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("rst_reached_3", 64'(n_xfer), 64'd3);
    #2 rst = 1'b1;
    #1 check_idle("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_no_done", 64'(done_cnt), 64'(base));
    prep_run(0);
    pulse_start();
    wait_done("replay", base);
    chk("replay_count", 64'(n_xfer), 64'd8);

    // randomized matrices with random out_ready
    for (int it = 0; it < 6; it++) begin
      tot = 0;
      for (int r = 0; r < H_NUM_OF_ROWS; r++) begin
        m_len[r] = ROW_LEN_WIDTH'($urandom_range(0, H_NUM_OF_COLS));
        m_nn[r]  = NUM_NODE_WIDTH'($urandom_range(1, NUM_OF_NODES));
        m_fl[r]  = 1'($urandom_range(0, 1));
        tot += int'(m_len[r]);
      end
      for (int i = 0; i < 32; i++) begin
        m_col[i] = COL_IDX_WIDTH'($urandom_range(0, H_NUM_OF_COLS - 1));
        m_val[i] = DATA_WIDTH'($urandom_range(0, 255));
      end
      prep_run(2);
      base = done_cnt;
      pulse_start();
      wait_done($sformatf("rand%0d", it), base);
      chk($sformatf("rand%0d_count", it), 64'(n_xfer), 64'(tot));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/h_csr_read_sched.md
# h_csr_read_sched

Read scheduler for the sparse feature matrix H stored in CSR form across the node_info, col_idx and value BRAMs. Once all three BRAMs report load done and a start pulse arrives, it walks node_info row by row. For each row it issues the col_idx/value BRAM reads and delivers a valid/ready element stream, tagged with row metadata, to the SpMM (W·H) stage. It is the only agent driving port B of the three H BRAMs.

## Interface
- DATA_WIDTH, 8, value width
- H_NUM_OF_ROWS, 5, rows of H (nodes scheduled per run)
- H_NUM_OF_COLS, 5, columns of H
- NUM_OF_NODES, 5, subgraph node count bound
- BRAM_ADDR_WIDTH, 32, BRAM address width
- derived: COL_IDX_WIDTH = $clog2(H_NUM_OF_COLS); ROW_LEN_WIDTH = $clog2(H_NUM_OF_COLS); NUM_NODE_WIDTH = $clog2(NUM_OF_NODES); NODE_INFO_WIDTH = ROW_LEN_WIDTH+NUM_NODE_WIDTH+1; H_INDEX_WIDTH = $clog2(H_NUM_OF_ROWS)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  run request, sampled in IDLE only
- H_col_idx_BRAM_load_done, H_value_BRAM_load_done, H_node_info_BRAM_load_done  in  1 each  load complete
- H_node_info_BRAM_enb / _addrb / _dout  out/out/in  1 / BRAM_ADDR_WIDTH / NODE_INFO_WIDTH  node_info read port; dout = {row_len, num_node, flag}
- H_col_idx_BRAM_enb / _addrb / _dout  out/out/in  1 / BRAM_ADDR_WIDTH / COL_IDX_WIDTH
- H_value_BRAM_enb / _addrb / _dout  out/out/in  1 / BRAM_ADDR_WIDTH / DATA_WIDTH
- out_valid  out  1; out_ready  in  1  element handshake
- out_col_idx  out  COL_IDX_WIDTH; out_value  out  DATA_WIDTH
- out_row_idx  out  H_INDEX_WIDTH; out_num_node  out  NUM_NODE_WIDTH; out_flag  out  1  (row metadata)
- out_row_last  out  1  last element of row
- busy  out  1; done  out  1  (one-cycle pulse)

## Operation
- FSM states: IDLE, INFO_REQ, INFO_CAP, STREAM, DRAIN, DONE.
- IDLE: if start and all three load_done are 1, clear row_cnt and nnz_ptr, go to INFO_REQ. If start arrives with any load_done at 0, ignore it.
- INFO_REQ: node_info enb=1, addrb=row_cnt. Go to INFO_CAP.
- INFO_CAP: latch {row_len, num_node, flag}. If row_len==0, skip the row: row_cnt++ and go to INFO_REQ, or to DRAIN if this was the last row. Otherwise load rem=row_len and go to STREAM.
- STREAM: issue a col_idx+value read (both enb=1, addrb=nnz_ptr) when count+inflight−pop < 2. Each issue increments nnz_ptr and decrements rem.
  - Every issued read carries its tag {row_cnt, num_node, flag, last=(rem==1)}.
  - When rem reaches 0: row_cnt++. Go to INFO_REQ if rows remain, else DRAIN.
- DRAIN: wait until the FIFO is empty and nothing is in flight, then DONE.
- DONE: done=1 for one cycle, then IDLE.
- BRAM read latency is 1 cycle. Data plus tag enter a 2-entry FIFO the cycle after issue. The FIFO head drives the out_* outputs.
- busy=1 in every state except IDLE.
- nnz_ptr is BRAM_ADDR_WIDTH wide and never wraps within a run (total nnz ≤ H_NUM_OF_ROWS·H_NUM_OF_COLS). row_cnt does not wrap; it stops at H_NUM_OF_ROWS.
- start asserted while busy: ignored.
- Handshake: an element transfers on out_valid & out_ready. Once out_valid is high, out_* stay stable until the transfer. out_valid never depends combinationally on out_ready.
- Simultaneous FIFO push and pop at count 2 is impossible because of the issue rule. At count 1, push and pop in the same cycle keeps count at 1.

## Timing
- Reset values: all enb=0, all addrb=0, out_valid=0, out_* data=0, busy=0, done=0, FSM=IDLE, FIFO empty.
- rst asserted mid-run: immediate return to reset values. In-flight reads are discarded, no done pulse.
- First out_valid: 4 cycles after the cycle start is sampled (INFO_REQ, INFO_CAP, read issue, FIFO push).
- Throughput: 1 element/cycle within a row while out_ready=1. Row boundary adds a 2-cycle out_valid bubble for the info fetch.
- done pulses 2 cycles after the final transfer (DRAIN exit, then DONE).

## Structure
- Shared package gat_pkg holds:
  - width localparams (COL_IDX_WIDTH, ROW_LEN_WIDTH, NUM_NODE_WIDTH, NODE_INFO_WIDTH)
  - packed struct node_info_t {row_len, num_node, flag}
  - packed struct h_elem_t {col_idx, value, row_idx, num_node, flag, last}
  - FSM state enum
- One sub-module: stream_skid_fifo, a 2-entry synchronous FIFO of h_elem_t with count output.

## Test plan
- Nominal run, out_ready=1.
  - Stimulus: node_info row_len {2,2,2,1,1}, flag row0=1, num_node=5; col_idx {0,4,2,4,1,3,2,4}; value {2,9,7,8,6,5,3,1}.
  - Response: (0,2),(4,9)L row0 flag=1; (2,7),(4,8)L row1; (1,6),(3,5)L row2; (2,3)L row3; (4,1)L row4. 8 transfers, then one done pulse.
- Backpressure: same data with out_ready toggled 1-0-0-1 → identical ordered stream, out_* stable while stalled, no element lost or duplicated.
- Empty row: row_len {2,0,1,...} → row1 emits nothing, row2 has row_idx=2, nnz_ptr contiguous.
- Gating: start with H_value_BRAM_load_done=0 → stays IDLE, no enb. Start pulse during STREAM → ignored.
- Reset mid-STREAM (after 3 transfers): all outputs return to reset values. A fresh start replays from element (0,2).
- Timing check: first out_valid exactly 4 cycles after start. 2-cycle bubble at each row boundary.
